// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern and length.
// It supports overlap or non-overlap detection, a saturating match counter and a fill-level output.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] fill
);

    // Strobe semantics: in is consumed on every rising edge where en=1 and cfg_we=0.
    // There is no back-pressure, and cfg_we discards any sample offered in the same cycle.
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W:0]   ONE_W   = (LEN_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovl_q;
    logic             match_q;
    logic             accept;
    logic             hit;

    assign accept   = en & ~cfg_we;
    assign len_in   = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
    assign hist_nxt = {hist_q[PAT_W-2:0], in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (len_q > LEN_W'(i));
        end
    end

    // The hit condition looks at the history including the incoming bit.
    // This lets match be registered on the same edge that accepts the last bit.
    assign hit = accept
               && (len_q != '0)
               && (({1'b0, fill_q} + ONE_W) >= {1'b0, len_q})
               && (((hist_nxt ^ pat_q) & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
        end else if (cfg_we) begin
            pat_q <= pattern;
            len_q <= len_in;
            ovl_q <= overlap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_we) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (accept) begin
            hist_q <= hist_nxt;
            if (hit && !ovl_q) begin
                fill_q <= '0;
            end else if (fill_q != LEN_MAX) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
        end
    end

    // When cnt_clr and a hit occur together, the hit counts after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cfg_we) begin
            cnt_q <= '0;
        end else if (hit) begin
            if (cnt_clr) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param.
// Stimulus is driven 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             in;
    logic             cfg_we;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [LEN_W-1:0] fill;

    int vectors;
    int miscompares;

    seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .cfg_we(cfg_we),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one bit.
    // After this task returns, the outputs reflect the edge that sampled the bit.
    task automatic push(input logic b, input logic clr);
        en = 1'b1;
        in = b;
        cnt_clr = clr;
        @(posedge clk);
        #1;
        en = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic idle();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_we = 1'b1;
        pattern = p;
        pat_len = l;
        overlap = o;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check("cfg_fill", fill, 0);
        check("cfg_match", match, 0);
        check("cfg_count", match_count, 0);
    endtask

    logic [9:0] stream;
    logic [9:0] exp_novl;
    logic [9:0] exp_ovl;
    logic [7:0] a5;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b0; in = 1'b0; cfg_we = 1'b0;
        pattern = '0; pat_len = '0; overlap = 1'b0; cnt_clr = 1'b0;
        #1;
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_fill", fill, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with detection disabled: no match ever, fill saturates.
        for (int i = 0; i < 100; i++) begin
            push(1'($urandom_range(0, 1)), 1'b0);
            check("idle_match", match, 0);
        end
        check("idle_fill", fill, 8);
        check("idle_count", match_count, 0);

        // Stream 0110110110, first bit is MSB of the vector.
        stream   = 10'b0110110110;
        exp_novl = 10'b0001000001;
        exp_ovl  = 10'b0001001001;

        cfg(8'b0000_0110, 4'd4, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            push(stream[i], 1'b0);
            check("novl_match", match, exp_novl[i]);
        end
        check("novl_count", match_count, 2);

        cfg(8'b0000_0110, 4'd4, 1'b1);
        for (int i = 9; i >= 0; i--) begin
            push(stream[i], 1'b0);
            check("ovl_match", match, exp_ovl[i]);
        end
        check("ovl_count", match_count, 3);

        // en gaps do not break a partial match.
        cfg(8'b0000_0101, 4'd3, 1'b0);
        push(1'b1, 1'b0); check("gap_m1", match, 0);
        idle(); idle();
        push(1'b0, 1'b0); check("gap_m2", match, 0);
        idle(); idle();
        push(1'b1, 1'b0); check("gap_hit", match, 1);
        idle(); check("gap_pulse_end", match, 0);
        check("gap_count", match_count, 1);

        // cfg_we takes priority over en, so the offered '1' is dropped.
        en = 1'b1; in = 1'b1;
        cfg(8'b0000_0101, 4'd3, 1'b0);
        en = 1'b0;
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        check("prio_match", match, 0);
        check("prio_fill", fill, 2);

        // Length 1: every bit equal to pattern[0] is a hit.
        cfg(8'b0000_0001, 4'd1, 1'b0);
        push(1'b1, 1'b0); check("len1_a", match, 1);
        push(1'b0, 1'b0); check("len1_b", match, 0);
        push(1'b1, 1'b0); check("len1_c", match, 1);
        check("len1_fill", fill, 0);
        push(1'b1, 1'b0); check("len1_d", match, 1);
        check("len1_count", match_count, 3);

        // A length above PAT_W is clamped to PAT_W.
        a5 = 8'hA5;
        cfg(8'hA5, 4'd12, 1'b1);
        for (int b = 7; b >= 0; b--) begin
            push(a5[b], 1'b0);
            check("clamp_match", match, (b == 0) ? 1 : 0);
        end

        // Full length, saturation at 255, cnt_clr on a hit.
        cfg(8'hA5, 4'd8, 1'b1);
        for (int n = 0; n < 300; n++) begin
            for (int b = 7; b >= 0; b--) begin
                push(a5[b], 1'b0);
                check("sat_match", match, (b == 0) ? 1 : 0);
            end
            if (n == 0) begin
                check("sat_first", match_count, 1);
            end
        end
        check("sat_count", match_count, 255);
        check("sat_fill", fill, 8);
        for (int b = 7; b >= 0; b--) begin
            push(a5[b], (b == 0) ? 1'b1 : 1'b0);
        end
        check("clrhit_match", match, 1);
        check("clrhit_count", match_count, 1);
        push(1'b1, 1'b1);
        check("clr_only_count", match_count, 0);

        // Asynchronous reset mid-pattern.
        cfg(8'b0000_0110, 4'd4, 1'b0);
        push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
        check("pre_rst_count", match_count, 1);
        push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        check("pre_rst_fill", fill, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_fill", fill, 0);
        check("arst_match", match, 0);
        check("arst_count", match_count, 0);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
            push(1'b0, 1'b0);
            check("post_rst_match", match, 0);
        end
        check("post_rst_count", match_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed-pattern 0110 detector. The pattern (up to PAT_W bits) and its length are runtime-programmable, and overlapping or non-overlapping detection is selectable. It adds a sample-enable qualifier, a saturating match counter and a fill-level output. It sits on serial input paths, such as framing/sync-word search, and feeds control FSMs with a registered match pulse.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(PAT_W+1), width of pattern-length and fill fields (derived; do not override)
CNT_W, 8, width of match counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample strobe; in is accepted only when en=1
in  input  1  serial data bit
cfg_we  input  1  config write strobe; latches pattern, pat_len, overlap; clears progress and count
pattern  input  PAT_W  pattern; active bits [pat_len-1:0], bit pat_len-1 received first, bit 0 last
pat_len  input  LEN_W  pattern length; 0 = disabled; values >PAT_W clamp to PAT_W
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
match  output  1  one-cycle pulse, registered
match_count  output  CNT_W  number of matches, saturating
fill  output  LEN_W  valid history bits since last restart, saturates at PAT_W

Behaviour:
- Reset: clk and rst share one clock domain, and reset is asynchronous and active-high. Under rst: shadow config pattern=0, pat_len=0 (disabled), overlap=0; history=0; fill=0; match=0; match_count=0.
- Config: on cfg_we=1, latch the inputs into shadow registers. Clamp pat_len to PAT_W. Clear history, fill and match_count. The next cycle's match=0. Detection uses only the shadow config.
- cfg_we has priority over en in the same cycle; that sample is discarded.
- Accept: when en=1 and cfg_we=0, next history = {history[PAT_W-2:0], in} and fill = min(fill+1, PAT_W).
- Hit condition, evaluated on the accepted sample:
  - pat_len != 0;
  - fill+1 >= pat_len;
  - the low pat_len bits of {history[PAT_W-2:0], in} equal pattern[pat_len-1:0].
- Match timing: on a hit, match=1 in the cycle after the accepting edge. This gives 1-cycle latency after the final pattern bit is sampled. Otherwise match=0. match is never held for more than one cycle per hit.
- en=0: history and fill hold, and match deasserts next cycle. Gaps in en do not break a partial match.
- overlap=1: after a hit, history and fill continue normally, so suffix bits can start the next match. Example: pattern 0110, stream 0110110 gives 2 hits.
- overlap=0: the hit sample is consumed and fill is set to 0, so the next match needs pat_len fresh bits. History contents are irrelevant once fill=0. The same stream gives 1 hit.
- match_count: increments on each hit and saturates at 2^CNT_W-1.
  - cnt_clr=1 clears it to 0.
  - cnt_clr together with a hit in the same cycle gives count=1 (the hit is counted after the clear).
  - cfg_we clears it to 0 regardless.
- pat_len=1: every accepted bit equal to pattern[0] is a hit. With overlap=0, fill returns to 0 on each hit, with the same effect.
- Reset asserted mid-pattern: all progress is lost immediately; match and count read 0 while rst=1.

Test Plan:
- Reset/idle: rst=1 then 0, pat_len=0, stream of 100 random bits with en=1 -> match never 1, match_count=0, fill saturates at 8.
- Non-overlap 0110: cfg pattern=8'b0000_0110, pat_len=4, overlap=0; stream 0,1,1,0,1,1,0,1,1,0 -> match pulses one cycle after bit 4 and bit 10 only; match_count=2.
- Overlap 0110: same stream, overlap=1 -> match after bits 4, 7 and 10; match_count=3.
- en gaps and cfg priority: pattern 101, pat_len=3, bits 1,0,1 with en low for 2 cycles between each bit -> exactly one match, 1 cycle after the third accepted bit. Then cfg_we together with en=1 -> sample ignored, fill=0.
- Full length and saturation: PAT_W=8, pattern 8'hA5, pat_len=8, overlap=1, CNT_W=8; repeat A5 300 times -> match_count sticks at 255. cnt_clr on a hit cycle -> count reads 1.
- Async reset mid-pattern: after 3 of 4 bits of 0110, pulse rst between clock edges -> fill, match and count go 0 immediately. pat_len reads back disabled, so no match occurs until the next cfg_we.
